// File: rtl/fifo_rr_scheduler_pkg.sv
// rtl/fifo_rr_scheduler_pkg.sv - shared types and defaults for the round-robin FIFO scheduler
// Purpose: state encoding, default parameters and channel-index width helper.
// Ports: none (package).
package fifo_rr_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_BURST  = 2;

  // Index width for n channels; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W = ch_width(DEF_NUM_CH);

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// rtl/fifo_rr_scheduler_rr_pick.sv - combinational rotating priority encoder
// Purpose: find the first asserted request at or after ptr, wrapping around.
// Ports:
//   req     in   NUM_CH  request vector, bit i = channel i
//   ptr     in   CH_W    channel with highest priority
//   gnt_idx out  CH_W    first requesting channel from ptr upward (ptr when none)
//   any_req out  1       at least one request asserted
module fifo_rr_scheduler_rr_pick
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_req
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W:0]       sum;

  // Rotate so that bit k of rot is channel (ptr+k) mod NUM_CH.
  assign dbl     = {req, req} >> ptr;
  assign rot     = dbl[NUM_CH-1:0];
  assign any_req = |req;

  // Walk offsets from the far end down so the smallest offset wins.
  always_comb begin
    gnt_idx = ptr;
    sum     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (CH_W + 1)'(k);
        if (sum >= (CH_W + 1)'(NUM_CH)) begin
          sum = sum - (CH_W + 1)'(NUM_CH);
        end
        gnt_idx = sum[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin drain of per-VC FIFOs into one egress FIFO
// Purpose: grant one source at a time, pop up to BURST words, push them to the sink.
// Ports:
//   clk             in   1              rising-edge clock
//   reset           in   1              synchronous active-high reset
//   fifo_empty      in   NUM_CH         source empty flags
//   fifo_data       in   NUM_CH*DATA_W  source data_out, channel i at [i*DATA_W +: DATA_W]
//   out_almost_full in   1              sink almost_full
//   fifo_pop        out  NUM_CH         one-hot pop strobe to sources
//   out_push        out  1              push strobe to sink
//   out_data        out  DATA_W         word to sink, valid with out_push
//   grant_id        out  CH_W           channel currently granted
//   busy            out  1              high while serving a grant
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST  = DEF_BURST,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  input  logic                     out_almost_full,
  output logic [NUM_CH-1:0]        fifo_pop,
  output logic                     out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          grant_id,
  output logic                     busy
);

  localparam int                BC_W       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BC_W-1:0]   BURST_LAST = BC_W'(BURST - 1);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [BC_W-1:0]   burst_cnt;
  logic              push_q;
  logic [CH_W-1:0]   sel_q;

  logic [NUM_CH-1:0] req_vec;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic [CH_W-1:0]   next_ptr;
  logic              cur_empty;
  logic              pop_ok;

  assign req_vec = ~fifo_empty;

  fifo_rr_scheduler_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req     (req_vec),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  assign cur_empty = fifo_empty[grant_id];
  assign next_ptr  = (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;

  // Mealy pop: reset gates it so a reset mid-burst consumes nothing.
  assign pop_ok = (state == ST_SERVE) && !reset && !cur_empty && !out_almost_full;

  always_comb begin
    fifo_pop = '0;
    if (pop_ok) begin
      fifo_pop[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      push_q    <= 1'b0;
      sel_q     <= '0;
    end else begin
      // Source read latency is one cycle, so the word arrives with push_q.
      push_q <= |fifo_pop;
      sel_q  <= grant_id;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            state     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          // Empty beats almost_full: a drained source gives up its grant.
          if (cur_empty) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else if (!out_almost_full) begin
            if (burst_cnt == BURST_LAST) begin
              rr_ptr <= next_ptr;
              state  <= ST_IDLE;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == CH_W'(i)) begin
        out_data = fifo_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_push = push_q;
  assign busy     = (state == ST_SERVE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - self-checking bench for fifo_rr_scheduler
module tb_fifo_rr_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 12;
  localparam int BURST  = 2;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic                     out_almost_full;
  logic [NUM_CH-1:0]        fifo_pop;
  logic                     out_push;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          grant_id;
  logic                     busy;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .BURST  (BURST),
    .CH_W   (CH_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .out_almost_full (out_almost_full),
    .fifo_pop        (fifo_pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  // Source FIFO contents and their registered data_out.
  logic [DATA_W-1:0] src_q [NUM_CH][$];
  logic [DATA_W-1:0] dout  [NUM_CH];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: serving flag, granted channel, words taken, priority pointer.
  bit                m_serve;
  int                m_gnt, m_cnt, m_ptr;
  bit                m_push;
  logic [DATA_W-1:0] m_word;

  logic [NUM_CH-1:0] ob_pop;
  bit                ob_push, ob_busy;
  bit                prev_busy = 1'b0;
  int                ob_gnt;
  logic [DATA_W-1:0] out_log [$];
  int                gnt_log [$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_empty[i] = (src_q[i].size() == 0);
      fifo_data[i*DATA_W +: DATA_W] = dout[i];
    end
  endtask

  task automatic model_step();
    bit                pop_exp;
    logic [NUM_CH-1:0] pop_vec;
    int                c;
    if (reset) begin
      check_eq("pop_in_reset", fifo_pop, 0);
      m_serve = 0; m_gnt = 0; m_cnt = 0; m_ptr = 0; m_push = 0;
      return;
    end
    check_eq("busy", busy, m_serve);
    check_eq("grant_id", grant_id, m_gnt);
    check_eq("out_push", out_push, m_push);
    if (m_push) check_eq("out_data", out_data, m_word);
    pop_exp = m_serve && (src_q[m_gnt].size() > 0) && !out_almost_full;
    pop_vec = '0;
    if (pop_exp) pop_vec[m_gnt] = 1'b1;
    check_eq("fifo_pop", fifo_pop, pop_vec);
    m_push = pop_exp;
    if (pop_exp) m_word = src_q[m_gnt][0];
    if (!m_serve) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (src_q[c].size() > 0) begin
          m_gnt = c; m_cnt = 0; m_serve = 1;
          break;
        end
      end
    end else if (src_q[m_gnt].size() == 0) begin
      m_ptr = (m_gnt + 1) % NUM_CH; m_serve = 0;
    end else if (!out_almost_full) begin
      m_cnt++;
      if (m_cnt == BURST) begin
        m_ptr = (m_gnt + 1) % NUM_CH; m_serve = 0;
      end
    end
  endtask

  // One clock: observe and check at negedge, then emulate the sources after the edge.
  task automatic tick();
    logic [NUM_CH-1:0] pops;
    @(negedge clk);
    ob_pop = fifo_pop; ob_push = out_push; ob_busy = busy; ob_gnt = int'(grant_id);
    if (!reset) begin
      if (ob_push) out_log.push_back(out_data);
      if (ob_busy && !prev_busy) gnt_log.push_back(ob_gnt);
      prev_busy = ob_busy;
    end else begin
      prev_busy = 1'b0;
    end
    model_step();
    pops = fifo_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pops[i] && src_q[i].size() > 0) dout[i] = src_q[i].pop_front();
    end
    drive_src();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
    out_log.delete();
    gnt_log.delete();
    drive_src();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_pop(input int ch, input string tag);
    int t;
    t = 0;
    while (!ob_pop[ch] && t < 20) begin
      tick();
      t++;
    end
    if (!ob_pop[ch]) check_eq(tag, 0, 1);
  endtask

  initial begin
    int n0, pops_seen, held_bad;
    reset = 1'b1;
    out_almost_full = 1'b0;
    ob_pop = '0;
    for (int i = 0; i < NUM_CH; i++) dout[i] = '0;
    clear_all();

    // Reset state
    do_reset(4);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_push", out_push, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_pop", fifo_pop, 0);

    // Single channel burst
    src_q[1].push_back(12'h00A);
    src_q[1].push_back(12'h00B);
    drive_src();
    repeat (8) tick();
    check_eq("single_cnt", out_log.size(), 2);
    check_eq("single_w0", (out_log.size() > 0) ? int'(out_log[0]) : -1, 12'h00A);
    check_eq("single_w1", (out_log.size() > 1) ? int'(out_log[1]) : -1, 12'h00B);
    check_eq("single_idle", busy, 0);
    gnt_log.delete();
    src_q[1].push_back(12'h111);
    src_q[2].push_back(12'h222);
    drive_src();
    repeat (8) tick();
    check_eq("single_ptr_next", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);

    // Fairness across all channels
    do_reset(2);
    clear_all();
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 3; k++) src_q[i].push_back(DATA_W'(16 * i + k));
    drive_src();
    repeat (40) tick();
    check_eq("fair_grants", gnt_log.size(), 8);
    for (int j = 0; j < 8; j++)
      check_eq("fair_order", (gnt_log.size() > j) ? gnt_log[j] : -1, j % NUM_CH);
    check_eq("fair_words", out_log.size(), 12);
    for (int j = 0; j < 12; j++)
      check_eq("fair_data", (out_log.size() > j) ? int'(out_log[j]) : -1,
               (j < 8) ? 16 * (j / 2) + (j % 2) : 16 * (j - 8) + 2);

    // Backpressure mid-burst
    do_reset(2);
    clear_all();
    for (int k = 0; k < 4; k++) src_q[2].push_back(DATA_W'($urandom));
    drive_src();
    wait_pop(2, "bp_wait_pop");
    out_almost_full = 1'b1;
    n0 = out_log.size();
    pops_seen = 0; held_bad = 0;
    repeat (5) begin
      tick();
      if (ob_pop != 0) pops_seen++;
      if (ob_gnt != 2 || !ob_busy) held_bad++;
    end
    check_eq("bp_no_pop", pops_seen, 0);
    check_eq("bp_grant_held", held_bad, 0);
    check_eq("bp_push_le1", (out_log.size() - n0) <= 1, 1);
    out_almost_full = 1'b0;
    repeat (15) tick();
    check_eq("bp_total", out_log.size(), 4);

    // Early empty on last channel wraps pointer to 0
    do_reset(2);
    clear_all();
    src_q[3].push_back(12'h3F1);
    drive_src();
    repeat (6) tick();
    check_eq("early_cnt", out_log.size(), 1);
    check_eq("early_idle", busy, 0);
    gnt_log.delete();
    src_q[0].push_back(12'h0A0);
    src_q[3].push_back(12'h3A3);
    drive_src();
    repeat (4) tick();
    check_eq("early_wrap", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    // Reset mid-burst
    do_reset(2);
    clear_all();
    for (int k = 0; k < 4; k++) src_q[1].push_back(DATA_W'(12'h100 + k));
    drive_src();
    wait_pop(1, "rmb_wait_pop");
    reset = 1'b1;
    tick();
    check_eq("rmb_pop", ob_pop, 0);
    reset = 1'b0;
    check_eq("rmb_push", out_push, 0);
    check_eq("rmb_grant", grant_id, 0);
    check_eq("rmb_busy", busy, 0);

    // Idle with every source empty
    clear_all();
    pops_seen = 0;
    repeat (10) begin
      tick();
      if (ob_pop != 0 || ob_busy) pops_seen++;
    end
    check_eq("idle_activity", pops_seen, 0);
    check_eq("idle_push", out_log.size(), 0);

    // Randomized traffic against the model
    do_reset(2);
    clear_all();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(3) == 0 && src_q[i].size() < 6) src_q[i].push_back(DATA_W'($urandom));
      out_almost_full = ($urandom_range(4) == 0);
      reset = ($urandom_range(499) == 0);
      drive_src();
      tick();
    end
    reset = 1'b0;
    out_almost_full = 1'b0;
    drive_src();
    repeat (80) tick();
    for (int i = 0; i < NUM_CH; i++) check_eq("drain_empty", src_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
